// File: rtl/regfile_mp.sv
// Multi-ported register file: 2 combinational read ports, 1 write port, and a busy scoreboard.
// After reset, a sweep zeroes every entry. Define REGFILE_MP_BYPASS_EN to forward write data to the read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              bset,
  input  logic [ADDR_W-1:0] ba
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run;
  logic wrOk;
  logic setOk;

  assign run   = (state_q == RUN) && !rst;
  assign wrOk  = run && we && ((ZERO_REG == 0) || (wa != '0));
  assign setOk = run && bset && ((ZERO_REG == 0) || (ba != '0));

  // A set on the same entry as a write is applied last, so it wins.
  always_comb begin
    busy_d = busy_q;
    if (wrOk) busy_d[wa] = 1'b0;
    if (setOk) busy_d[ba] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: busy_q <= busy_d;
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Data storage has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (wrOk) begin
        mem_q[wa] <= wd;
      end
    end
  end

  always_comb begin
    rd1 = mem_q[ra1];
    rd2 = mem_q[ra2];
`ifdef REGFILE_MP_BYPASS_EN
    if (wrOk && (wa == ra1)) rd1 = wd;
    if (wrOk && (wa == ra2)) rd2 = wd;
`endif
    if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
    if (!run) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

  assign busy1 = run && busy_q[ra1];
  assign busy2 = run && busy_q[ra2];
  assign ready = ready_q && !rst;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_REG, default 1; 1 = entry 0 hardwired to zero, never written, never busy.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ready  output  1  high when the clear sequence is complete and the file accepts operations.
REQ-007 ra1, ra2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-008 rd1, rd2  output  DATA_W  combinational read data, ports 1 and 2.
REQ-009 busy1, busy2  output  1  scoreboard busy bit of ra1 and ra2.
REQ-010 we  input  1  write enable.
REQ-011 wa  input  ADDR_W  write address.
REQ-012 wd  input  DATA_W  write data.
REQ-013 bset  input  1  scoreboard set request: mark entry ba pending.
REQ-014 ba  input  ADDR_W  scoreboard set address.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR, each rising edge with rst low SHALL write 0 to entry cnt, then increment cnt.
REQ-017 When cnt == DEPTH-1 in CLEAR, the FSM SHALL enter RUN, and ready SHALL be 1 from the next cycle.
REQ-018 With rst low, ready SHALL rise exactly DEPTH cycles after the first rising edge.
REQ-019 In CLEAR: we and bset SHALL be ignored; rd1, rd2, busy1 and busy2 SHALL read 0.
REQ-020 In RUN, with we=1 and wa non-zero (or ZERO_REG=0), entry wa SHALL take wd at the rising edge.
REQ-021 If ZERO_REG=1, a read of address 0 SHALL return 0 regardless of stored state.
REQ-022 In RUN, rd1 and rd2 SHALL reflect the stored entry at ra1 and ra2 combinationally.
REQ-023 Both read ports SHALL be independent and may address the same entry.
REQ-024 In RUN, a qualifying write to an entry SHALL clear its busy bit at that edge.
REQ-025 In RUN, bset=1 SHALL set busy[ba] at the edge; ba=0 is ignored when ZERO_REG=1.
REQ-026 If bset and we target the same entry in the same cycle, the set SHALL win and the busy bit ends 1; the data write still occurs.
REQ-027 busy1 and busy2 SHALL reflect the registered busy bits only; there SHALL be no same-cycle bypass of busy.

Reset
REQ-028 On rst=1 at a rising edge, the block SHALL set state to CLEAR, cnt to 0, ready to 0 and all busy bits to 0.
REQ-029 Data entries are not reset directly; they SHALL be zeroed by the CLEAR sweep.
REQ-030 Assertion of rst during CLEAR or RUN SHALL restart the sweep from entry 0.
REQ-031 While rst=1, all outputs SHALL read 0.

Configuration
REQ-032 Macro REGFILE_MP_BYPASS_EN SHALL control write-to-read bypass.
REQ-033 With the macro defined, in RUN, when we=1, wa == ra_n and wa is writable, rd_n SHALL equal wd in the same cycle.
REQ-034 Without the macro, rd_n SHALL return the pre-write stored value in that cycle and the new value from the next cycle.

Verification
REQ-035 Reset sweep: defaults, rst high 2 cycles then low -> ready=0 for 32 cycles, ready=1 on cycle 32, all 32 entries read 0.
REQ-036 Write/read: we=1, wa=5, wd=0xDEADBEEF; next cycle ra1=5, ra2=5 -> rd1=rd2=0xDEADBEEF; write wa=0 -> rd of address 0 stays 0.
REQ-037 Bypass: wa=7, wd=0x12345678, ra1=7 in the same cycle -> rd1=0x12345678 with REGFILE_MP_BYPASS_EN defined; prior value 0 without it.
REQ-038 Scoreboard: bset with ba=3 -> busy for address 3 =1 next cycle; write wa=3 -> busy=0 next cycle; bset and we both at 3 in one cycle -> busy=1 and data updated.
REQ-039 Mid-operation reset: write 0xA5 to entry 9, set busy on 9, pulse rst for 1 cycle -> ready=0, busy for 9 =0; after 32 cycles entry 9 reads 0.
REQ-040 CLEAR blocking: we=1, wa=4, wd=0xFF and bset with ba=4 while ready=0 -> after ready rises, entry 4 reads 0 and busy for 4 =0.
